// File: rtl/exec_unit_mc.sv
// exec_unit_mc: execute unit for RV32I integer ops and RV32M multiply/divide.
// The RV32I integer ops finish in one cycle. Multiply and divide take 32
// iterations: shift-add for multiply, restoring division for divide. Both work
// on operand magnitudes and apply the sign correction at the end.
module exec_unit_mc #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        alu_ctrl,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  ctrl_q;
  logic        neg_q;
  logic [31:0] mcand_q;
  logic [63:0] work_q;
  logic [31:0] result_q;
  logic        zero_q;

  logic [31:0] alu_res;
  logic        is_iter, is_div, div_special, a_neg, b_neg, neg_in;
  logic [31:0] a_mag, b_mag, special_res, imm_res;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] next_work, mul_fin;
  logic [31:0] div_raw, iter_res;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state == ITER);
  assign result    = result_q;
  assign zero      = zero_q;

  // Single-cycle integer ops; codes that are not defined produce zero.
  always_comb begin
    alu_res = 32'd0;
    case (alu_ctrl)
      5'b00000: alu_res = op_a + op_b;
      5'b01000: alu_res = op_a - op_b;
      5'b00001: alu_res = op_a << op_b[4:0];
      5'b00010: alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
      5'b00011: alu_res = {31'd0, (op_a < op_b)};
      5'b00100: alu_res = op_a ^ op_b;
      5'b00101: alu_res = op_a >> op_b[4:0];
      5'b01101: alu_res = $signed(op_a) >>> op_b[4:0];
      5'b00110: alu_res = op_a | op_b;
      5'b00111: alu_res = op_a & op_b;
      default:  alu_res = 32'd0;
    endcase
  end

  // Accept-time preparation: operand magnitudes, final sign, divide special cases.
  always_comb begin
    is_iter = (alu_ctrl[4:3] == 2'b10);
    is_div  = is_iter && alu_ctrl[2];
    if (is_div) begin
      a_neg = !alu_ctrl[0] && op_a[31];
      b_neg = !alu_ctrl[0] && op_b[31];
    end else begin
      a_neg = ((alu_ctrl[1:0] == 2'b01) || (alu_ctrl[1:0] == 2'b10)) && op_a[31];
      b_neg = (alu_ctrl[1:0] == 2'b01) && op_b[31];
    end
    a_mag  = a_neg ? (32'd0 - op_a) : op_a;
    b_mag  = b_neg ? (32'd0 - op_b) : op_b;
    neg_in = (is_div && alu_ctrl[1]) ? a_neg : (a_neg ^ b_neg);
    div_special = 1'b0;
    special_res = 32'd0;
    if (op_b == 32'd0) begin
      div_special = is_div;
      special_res = alu_ctrl[1] ? op_a : 32'hFFFF_FFFF;
    end else if (!alu_ctrl[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF)) begin
      div_special = is_div;
      special_res = alu_ctrl[1] ? 32'd0 : 32'h8000_0000;
    end
    imm_res = is_iter ? special_res : alu_res;
  end

  // One iteration step plus the sign fixup used when the last step completes.
  always_comb begin
    mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, mcand_q} : 33'd0);
    div_shift = work_q[63:31];
    div_diff  = div_shift - {1'b0, mcand_q};
    if (ctrl_q[2]) begin
      if (div_diff[32]) next_work = {div_shift[31:0], work_q[30:0], 1'b0};
      else              next_work = {div_diff[31:0], work_q[30:0], 1'b1};
    end else begin
      next_work = {mul_sum, work_q[31:1]};
    end
    mul_fin = neg_q ? (64'd0 - next_work) : next_work;
    div_raw = ctrl_q[1] ? next_work[63:32] : next_work[31:0];
    if (ctrl_q[2])                iter_res = neg_q ? (32'd0 - div_raw) : div_raw;
    else if (ctrl_q[1:0] == 2'd0) iter_res = mul_fin[31:0];
    else                          iter_res = mul_fin[63:32];
  end

  // Control FSM with registered result and zero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      ctrl_q   <= 3'd0;
      neg_q    <= 1'b0;
      mcand_q  <= 32'd0;
      work_q   <= 64'd0;
      result_q <= 32'd0;
      zero_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ctrl_q <= alu_ctrl[2:0];
            neg_q  <= neg_in;
            cnt    <= 5'd0;
            if (is_iter && !div_special) begin
              mcand_q <= is_div ? b_mag : a_mag;
              work_q  <= {32'd0, (is_div ? a_mag : b_mag)};
              state   <= ITER;
            end else begin
              result_q <= imm_res;
              zero_q   <= (imm_res == 32'd0);
              state    <= DONE;
            end
          end
        end
        ITER: begin
          work_q <= next_work;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result_q <= iter_res;
            zero_q   <= (iter_res == 32'd0);
            cnt      <= 5'd0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// tb_exec_unit_mc: directed test of exec_unit_mc. A cycle-level reference
// model, built from the arithmetic rules and handshake timing, is checked on
// every cycle. Hand-computed literals pin the expected results and latencies.
module tb_exec_unit_mc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit          m_started = 0;
  bit          m_fresh   = 0;
  bit          m_pending = 0;
  int          m_wait    = 0;
  logic [31:0] m_res     = 32'd0;

  exec_unit_mc #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // overall time limit
  initial begin
    #400000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // architectural result of one request, from plain arithmetic
  function automatic logic [31:0] modelResult(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea, eb, p;
    logic signed [31:0] sa;
    int ia, ib;
    int code;
    code = int'(c);
    sa = a;
    ia = a;
    ib = b;
    case (code)
      0:  return a + b;
      8:  return a - b;
      1:  return a << b[4:0];
      2:  return (ia < ib) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a ^ b;
      5:  return a >> b[4:0];
      13: return sa >>> b[4:0];
      6:  return a | b;
      7:  return a & b;
      16, 17, 18, 19: begin
        ea = (code == 17 || code == 18) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (code == 17) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (code == 16) ? p[31:0] : p[63:32];
      end
      20, 21, 22, 23: begin
        if (b == 32'd0) return (code >= 22) ? a : 32'hFFFF_FFFF;
        if ((code == 20 || code == 22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return (code == 20) ? 32'h8000_0000 : 32'd0;
        case (code)
          20:      return ia / ib;
          22:      return ia % ib;
          21:      return a / b;
          default: return a % b;
        endcase
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int modelWait(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    int code;
    code = int'(c);
    if (code < 16 || code > 23) return 0;
    if (code >= 20 && b == 32'd0) return 0;
    if ((code == 20 || code == 22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  // reference model advances on each rising edge from the inputs seen there
  always @(posedge clk) begin
    if (rst) begin
      m_started = 1;
      m_fresh   = 1;
      m_pending = 0;
      m_wait    = 0;
    end else if (m_pending) begin
      if (m_wait == 0) begin
        if (out_ready) m_pending = 0;
      end else begin
        m_wait = m_wait - 1;
      end
    end else if (in_valid) begin
      m_pending = 1;
      m_fresh   = 0;
      m_res     = modelResult(alu_ctrl, op_a, op_b);
      m_wait    = modelWait(alu_ctrl, op_a, op_b);
    end
  end

  // compare DUT outputs with the model every cycle, away from the clock edge
  always @(negedge clk) begin
    #2;
    if (m_started) begin
      checkOutput("in_ready", 32'(in_ready), 32'(!m_pending && !rst));
      checkOutput("out_valid", 32'(out_valid), 32'(m_pending && m_wait == 0));
      checkOutput("busy", 32'(busy), 32'(m_pending && m_wait > 0));
      if (m_pending && m_wait == 0) begin
        checkOutput("result", result, m_res);
        checkOutput("zero", 32'(zero), 32'(m_res == 32'd0));
      end
      if (m_fresh) begin
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_zero", 32'(zero), 32'd1);
      end
    end
  end

  // issue one request, measure latency, optionally hold off the consumer
  task automatic applyStimulus(input string name, input logic [4:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_lit,
                               input int exp_lat, input int hold);
    int lat;
    out_ready = (hold == 0);
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    alu_ctrl = ~c;
    op_a     = ~a;
    op_b     = b ^ 32'h5;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, "_value"}, result, exp_lit);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      alu_ctrl = 5'b00000;
      op_a     = i;
      op_b     = 32'd1;
      @(negedge clk);
    end
    if (hold > 0) begin
      checkOutput({name, "_held"}, result, exp_lit);
      checkOutput({name, "_held_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_ctrl  = 5'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("add",      5'b00000, 32'd7,          32'd5,          32'd12,         1,  0);
    applyStimulus("sub",      5'b01000, 32'd5,          32'd5,          32'd0,          1,  0);
    applyStimulus("sra",      5'b01101, 32'h8000_0000,  32'd33,         32'hC000_0000,  1,  0);
    applyStimulus("sltu",     5'b00011, 32'd1,          32'hFFFF_FFFF,  32'd1,          1,  0);
    applyStimulus("slt",      5'b00010, 32'd1,          32'hFFFF_FFFF,  32'd0,          1,  0);
    applyStimulus("sll",      5'b00001, 32'd1,          32'd31,         32'h8000_0000,  1,  0);
    applyStimulus("srl",      5'b00101, 32'h8000_0000,  32'd4,          32'h0800_0000,  1,  0);
    applyStimulus("xor",      5'b00100, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1,  0);
    applyStimulus("or",       5'b00110, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1,  0);
    applyStimulus("and",      5'b00111, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1,  0);
    applyStimulus("undef",    5'b01001, 32'd3,          32'd4,          32'd0,          1,  0);
    applyStimulus("mulh",     5'b10001, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  33, 0);
    applyStimulus("mul",      5'b10000, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFA,  33, 0);
    applyStimulus("mulhu",    5'b10011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33, 0);
    applyStimulus("mulhsu",   5'b10010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  33, 0);
    applyStimulus("div",      5'b10100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 0);
    applyStimulus("rem",      5'b10110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 0);
    applyStimulus("remu",     5'b10111, 32'd100,        32'd7,          32'd2,          33, 0);
    applyStimulus("divu0",    5'b10101, 32'd7,          32'd0,          32'hFFFF_FFFF,  1,  0);
    applyStimulus("rem0",     5'b10110, 32'd7,          32'd0,          32'd7,          1,  0);
    applyStimulus("div_ovf",  5'b10100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0);
    applyStimulus("rem_ovf",  5'b10110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  0);
    applyStimulus("backpres", 5'b00000, 32'd3,          32'd4,          32'd7,          1,  10);

    // reset in the middle of an iterative divide discards it
    alu_ctrl = 5'b10101;
    op_a     = 32'd100;
    op_b     = 32'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("mid_div_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus("add_after", 5'b00000, 32'd1, 32'd2, 32'd3, 1, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_unit_mc.md
# exec_unit_mc

Multi-cycle execute unit that consumes the 5-bit ALU control code produced by the ALU control decoder, together with two 32-bit operands, and returns a 32-bit result. It covers the RV32I integer ops in one cycle and the RV32M multiply/divide ops iteratively over 32 cycles. It sits between the decode/issue stage and writeback, with a valid/ready handshake on both sides.

## Interface
- DATA_W, 32, operand/result width; only 32 is supported.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- alu_ctrl  in  5  control code, encoded as {AluOp[2], func7[5], func3}.
- op_a  in  32  operand A (rs1).
- op_b  in  32  operand B (rs2 or immediate).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  32  result.
- zero  out  1  result == 0, registered alongside result.
- busy  out  1  iterative mul/div in progress.

## Operation
- States: IDLE, ITER, DONE.
  - in_ready = (state==IDLE) && !rst.
  - out_valid = (state==DONE).
  - busy = (state==ITER).
- IDLE, accept (in_valid && in_ready):
  - Capture alu_ctrl, op_a and op_b.
  - Single-cycle op: compute, register result and zero, go to DONE.
  - Mul/div op: load the iteration registers, clear the counter, go to ITER.
- Single-cycle codes:
  - 00000 add; 01000 sub; 00001 sll; 00010 slt (signed); 00011 sltu.
  - 00100 xor; 00101 srl; 01101 sra; 00110 or; 00111 and.
  - Shift amount is op_b[4:0].
  - slt and sltu return 32'h1 or 32'h0.
- Iterative codes:
  - 10000 mul (low 32 bits); 10001 mulh (s×s); 10010 mulhsu (s×u); 10011 mulhu (u×u).
  - 10100 div; 10101 divu; 10110 rem; 10111 remu.
- Any other code (01001–01100, 01110, 01111, 11xxx): single-cycle path, result 0.
- Multiply:
  - Take the operand magnitudes per the signedness of the code.
  - Shift-add over 32 iterations into a 64-bit accumulator.
  - Negate the 64-bit product if the sign bits differ (signed operands only).
  - mul selects bits [31:0]; the mulh variants select bits [63:32].
- Divide:
  - Restoring, 32 iterations, on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (signed ops only).
- Divide special cases go directly IDLE→DONE (single-cycle latency):
  - Divisor 0: div/divu → 32'hFFFF_FFFF; rem/remu → op_a.
  - Signed overflow (op_a = 32'h8000_0000, op_b = 32'hFFFF_FFFF): div → 32'h8000_0000; rem → 0.
- ITER:
  - Counter 0..31 increments every cycle.
  - At count 31, apply the final sign fixup, register result and zero, go to DONE.
- DONE:
  - result and zero are held stable until out_valid && out_ready, then go to IDLE.
  - No new request is accepted in DONE.
- Reset, in any state including mid-ITER: state IDLE, counter 0, result 0, zero 1, out_valid 0, busy 0. The in-flight op is discarded without output.

## Timing
- Request accepted at edge T.
- Single-cycle op or div special case: out_valid high from T+1.
- Mul/div: busy high for cycles T+1..T+32; out_valid high from T+33.
- Result transferred at edge R (out_valid && out_ready): in_ready high from R+1.
- Minimum issue interval is 2 cycles for single-cycle ops and 34 cycles for mul/div.
- in_valid with in_ready low is ignored. The requester holds its inputs until in_ready is high.
- Operands are captured at accept; changes to op_a, op_b or alu_ctrl afterward have no effect.
- out_ready held low: result and out_valid stay stable indefinitely.

## Test plan
- Reset release, then add 7 + 5 (code 00000), out_ready=1 → out_valid at T+1, result 12, zero 0; sub 5 − 5 (01000) → result 0, zero 1.
- sra 32'h8000_0000 by op_b = 33 (01101; shift amount 1) → 32'hC000_0000; sltu 1 vs 32'hFFFF_FFFF → 1; slt on the same operands → 0.
- mulh −2 × 3 (10001) → busy for 32 cycles, out_valid at T+33, result 32'hFFFF_FFFF; mul on the same operands → 32'hFFFF_FFFA.
- div −7 / 2 → 32'hFFFF_FFFD; rem −7 / 2 → 32'hFFFF_FFFF; divu 7 / 0 → 32'hFFFF_FFFF at T+1; div 32'h8000_0000 / −1 → 32'h8000_0000 at T+1.
- Backpressure: out_ready low for 10 cycles after out_valid → result held and in_ready stays 0; in_valid pulses in this window are not accepted.
- rst asserted at cycle T+10 of a divu → next cycle: IDLE, out_valid 0, result 0, in_ready 1 after rst drops; a following add completes normally.
